// File: rtl/mw_fifo_pkg.sv
// mw_fifo_pkg: default geometry, counter-width helper and entry-array type shared by the mw_fifo files.
package mw_fifo_pkg;
  localparam int DEF_N_ENTRIES   = 8;
  localparam int DEF_ENTRY_WIDTH = 32;
  localparam int DEF_ENQ_WIDTH   = 2;
  localparam int DEF_DEQ_WIDTH   = 2;
  function automatic int ctr_width(input int n);
    return $clog2(n) + 1;
  endfunction
  typedef logic [DEF_N_ENTRIES-1:0][DEF_ENTRY_WIDTH-1:0] entry_arr_t;
endpackage

// File: rtl/mw_fifo_lead_ones.sv
// lead_ones: counts consecutive ones starting at bit 0.
module lead_ones #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0]               in,
  output logic [$clog2(WIDTH+1)-1:0]     cnt
);
  localparam int CW = $clog2(WIDTH + 1);
  logic run;
  always_comb begin
    run = 1'b1;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      run = run & in[i];
      cnt = cnt + CW'(run);
    end
  end
endmodule

// File: rtl/mw_fifo.sv
// mw_fifo: multi-way circular FIFO with per-slot ready/valid, occupancy count and flush.
// Defining MW_FIFO_INIT_EN adds state load/observe ports.
module mw_fifo
  import mw_fifo_pkg::*;
#(
  parameter int N_ENTRIES   = DEF_N_ENTRIES,
  parameter int ENTRY_WIDTH = DEF_ENTRY_WIDTH,
  parameter int ENQ_WIDTH   = DEF_ENQ_WIDTH,
  parameter int DEQ_WIDTH   = DEF_DEQ_WIDTH,
  localparam int PTR_WIDTH  = $clog2(N_ENTRIES),
  localparam int CTR_WIDTH  = ctr_width(N_ENTRIES)
) (
  input  logic                                  clk,
  input  logic                                  rst_aL,
  output logic [ENQ_WIDTH-1:0]                  enq_ready,
  input  logic [ENQ_WIDTH-1:0]                  enq_valid,
  input  logic [ENQ_WIDTH-1:0][ENTRY_WIDTH-1:0] enq_data,
  input  logic [DEQ_WIDTH-1:0]                  deq_ready,
  output logic [DEQ_WIDTH-1:0]                  deq_valid,
  output logic [DEQ_WIDTH-1:0][ENTRY_WIDTH-1:0] deq_data,
  output logic [CTR_WIDTH-1:0]                  count,
  input  logic                                  flush
`ifdef MW_FIFO_INIT_EN
  ,
  input  logic                                  init,
  input  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] init_entry_state,
  input  logic [CTR_WIDTH-1:0]                  init_enq_ctr_state,
  input  logic [CTR_WIDTH-1:0]                  init_deq_ctr_state,
  output logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] current_entry_state,
  output logic [CTR_WIDTH-1:0]                  current_enq_ctr_state,
  output logic [CTR_WIDTH-1:0]                  current_deq_ctr_state
`endif
);
  localparam int EW = $clog2(ENQ_WIDTH + 1);
  localparam int DW = $clog2(DEQ_WIDTH + 1);
  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] entry_q, entry_d;
  logic [CTR_WIDTH-1:0] enq_ctr_q, enq_ctr_d, deq_ctr_q, deq_ctr_d, free;
  logic [PTR_WIDTH-1:0] enq_ptr, deq_ptr;
  logic [EW-1:0] n_enq;
  logic [DW-1:0] n_deq;
  // Handshake outputs come only from registered counters.
  always_comb begin
    count   = enq_ctr_q - deq_ctr_q;
    free    = CTR_WIDTH'(N_ENTRIES) - count;
    enq_ptr = enq_ctr_q[PTR_WIDTH-1:0];
    deq_ptr = deq_ctr_q[PTR_WIDTH-1:0];
    for (int i = 0; i < ENQ_WIDTH; i++) enq_ready[i] = free > CTR_WIDTH'(i);
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      deq_valid[i] = count > CTR_WIDTH'(i);
      deq_data[i]  = entry_q[deq_ptr + PTR_WIDTH'(i)];
    end
  end
  lead_ones #(.WIDTH(ENQ_WIDTH)) u_enq_lo (.in(enq_valid & enq_ready), .cnt(n_enq));
  lead_ones #(.WIDTH(DEQ_WIDTH)) u_deq_lo (.in(deq_valid & deq_ready), .cnt(n_deq));
  always_comb begin
    entry_d   = entry_q;
    enq_ctr_d = enq_ctr_q + CTR_WIDTH'(n_enq);
    deq_ctr_d = deq_ctr_q + CTR_WIDTH'(n_deq);
    for (int k = 0; k < ENQ_WIDTH; k++)
      if (k < int'(n_enq)) entry_d[enq_ptr + PTR_WIDTH'(k)] = enq_data[k];
    if (flush) begin
      entry_d   = '0;
      enq_ctr_d = '0;
      deq_ctr_d = '0;
    end
`ifdef MW_FIFO_INIT_EN
    if (init) begin
      entry_d   = init_entry_state;
      enq_ctr_d = init_enq_ctr_state;
      deq_ctr_d = init_deq_ctr_state;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      entry_q   <= '0;
      enq_ctr_q <= '0;
      deq_ctr_q <= '0;
    end else begin
      entry_q   <= entry_d;
      enq_ctr_q <= enq_ctr_d;
      deq_ctr_q <= deq_ctr_d;
    end
  end
`ifdef MW_FIFO_INIT_EN
  assign current_entry_state   = entry_q;
  assign current_enq_ctr_state = enq_ctr_q;
  assign current_deq_ctr_state = deq_ctr_q;
`endif
endmodule

// File: doc/mw_fifo.md
# mw_fifo

Multi-way circular FIFO accepting up to ENQ_WIDTH entries and releasing up to DEQ_WIDTH entries per cycle, in strict order. It is the superscalar successor of the single-port fifo and sits between the fetch/decode and dispatch/issue stages. Per-slot ready/valid handshakes, an occupancy count and synchronous flush let wide pipelines stall precisely on partial acceptance.

## Interface
- N_ENTRIES, 8: depth; power of two, ≥ max(ENQ_WIDTH, DEQ_WIDTH).
- ENTRY_WIDTH, 32: bits per entry.
- ENQ_WIDTH, 2: enqueue slots per cycle, ≥ 1.
- DEQ_WIDTH, 2: dequeue slots per cycle, ≥ 1.
- PTR_WIDTH (local), $clog2(N_ENTRIES); CTR_WIDTH (local), PTR_WIDTH+1.
- clk  in  1  single clock; all state updates on rising edge.
- rst_aL  in  1  asynchronous, active-low reset.
- enq_ready  out  ENQ_WIDTH  bit i = 1 iff free entries > i.
- enq_valid  in  ENQ_WIDTH  producer slot i holds data.
- enq_data  in  ENQ_WIDTH×ENTRY_WIDTH  slot 0 is the oldest.
- deq_ready  in  DEQ_WIDTH  consumer takes slot i.
- deq_valid  out  DEQ_WIDTH  bit i = 1 iff count > i.
- deq_data  out  DEQ_WIDTH×ENTRY_WIDTH  slot i = entry[(deq_ptr+i) mod N_ENTRIES].
- count  out  CTR_WIDTH  occupancy, 0..N_ENTRIES.
- flush  in  1  synchronous clear.

## Operation
- State: N_ENTRIES entry registers, and enq/deq counters of CTR_WIDTH bits. Pointers are the low PTR_WIDTH bits.
- count = enq_ctr − deq_ctr, computed mod 2^CTR_WIDTH. The extra MSB separates full from empty.
- Enqueue acceptance: n_enq = number of leading ones of (enq_valid & enq_ready), counted from slot 0. Slots past the first 0 are not accepted, even if valid and ready. Producers must compact their requests.
- Slot k < n_enq writes entry[(enq_ptr+k) mod N]. enq_ctr advances by n_enq.
- Dequeue: n_deq = number of leading ones of (deq_valid & deq_ready). deq_ctr advances by n_deq. Dequeue never modifies entry contents.
- enq_ready and deq_valid depend only on registered state, never on the same-cycle enq_valid or deq_ready. No combinational path runs from inputs to handshake outputs.
- Slots freed by a dequeue cannot be reused by an enqueue in the same cycle.
- Simultaneous enqueue and dequeue: count_next = count + n_enq − n_deq.
- Pointer wrap: all slot indices are taken mod N_ENTRIES. A burst that straddles entry N−1 continues at entry 0.
- Flush has priority over enqueue and dequeue. Both counters and all entries go to 0 on the next edge, and any enqueue in that cycle is dropped.
- Reset values (async, while rst_aL = 0):
  - counters and entries 0;
  - enq_ready all 1, deq_valid all 0, count 0, deq_data all 0.
- Reset asserted mid-burst drops all contents immediately; no partial write survives.

## Timing
- Enqueue-to-dequeue latency is 1 cycle: data enqueued at edge t appears on deq_data/deq_valid after edge t.
- count, enq_ready and deq_valid update only on clock edges or async reset.
- Full (count = N): enq_ready = 0. Empty: deq_valid = 0, and deq_data shows stale entry contents.
- Throughput: sustained min(ENQ_WIDTH, DEQ_WIDTH) entries/cycle, provided count stays ≥ DEQ_WIDTH and free entries ≥ ENQ_WIDTH.

## Configuration
- MW_FIFO_INIT_EN defined: adds the test ports init (in, 1), init_entry_state, init_enq_ctr_state, init_deq_ctr_state, and current_entry_state, current_enq_ctr_state, current_deq_ctr_state.
  - init=1 loads the supplied state synchronously.
  - init has priority below reset and above flush.
- Not defined: these ports are absent. Behaviour is otherwise identical.

## Structure
- Shared package mw_fifo_pkg: default width constants, the clog2-derived CTR_WIDTH helper, and the packed entry-array typedef.
- Natural sub-module: lead_ones (parameter WIDTH). Counts leading ones from bit 0 and outputs $clog2(WIDTH+1) bits. It is instantiated twice, once for enqueue and once for dequeue.
- Entry storage reuses reg_. Counters are add-by-n registers, not up_counter.

## Test plan
Default parameters (N=8, ENQ=2, DEQ=2) unless noted.
1. Reset, then idle: after rst_aL rises, count=0, enq_ready=2'b11, deq_valid=2'b00.
2. Enqueue enq_valid=11, data {B,A} = {0x2,0x1} → next cycle count=2, deq_valid=11, deq_data slot0=0x1, slot1=0x2.
3. Gap rule: enq_valid=2'b10 → nothing accepted, count unchanged.
4. Fill to 7 entries: enq_ready=2'b01. Enqueue 2 → only slot 0 accepted, count=8, enq_ready=00. Further enqueue is ignored.
5. Wrap: enqueue 6 / dequeue 6, then enqueue {0xB,0xA} at enq_ptr=6 → entries 6 and 7 written. Next burst goes to entries 0 and 1. Dequeue order is A, B, then the wrapped data.
6. Simultaneous: count=3, enqueue 2 + dequeue 2 → count=3 next cycle. Then flush together with enq_valid=11 → count=0, deq_valid=00, deq_data=0.
